// File: rtl/rgb_to_phase.sv
// rgb_to_phase: recovers a 16-bit hue phase from an 8-bit RGB sample.
// The minimum channel selects one of three 120-degree regions; the position
// inside the region is rise*21760/(rise+fall), computed by a 24-step
// restoring divider so the chromatic latency is fixed.
module rgb_to_phase (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  red,
  input  logic [7:0]  green,
  input  logic [7:0]  blue,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] phase,
  output logic        achromatic
);

  typedef enum logic [1:0] {IDLE, SETUP, DIV, DONE} state_t;

  localparam logic [15:0] REGION_SPAN = 16'd21760;  // one third of 65536, rounded to 0x5500

  state_t      state_reg, state_next;
  logic [7:0]  r_reg, g_reg, b_reg;
  logic [15:0] base_reg;
  logic [8:0]  den_reg;
  logic [23:0] dvd_reg;       // dividend shifts out the top, quotient shifts in the bottom
  logic [9:0]  rem_reg;
  logic [4:0]  cnt_reg;
  logic [15:0] phase_reg;
  logic        ach_reg;

  // Region selection from the captured sample (used in SETUP)
  logic        blue_min, red_min;
  logic [7:0]  mn, rise, fall;
  logic [15:0] base_sel;
  logic [8:0]  den_calc;
  logic [23:0] dvd_calc;

  // Blue wins ties, then red, then green.
  always_comb begin
    blue_min = (b_reg <= r_reg) && (b_reg <= g_reg);
    red_min  = !blue_min && (r_reg <= g_reg);
    mn       = 8'd0;
    rise     = 8'd0;
    fall     = 8'd0;
    base_sel = 16'd0;
    if (blue_min) begin
      mn       = b_reg;
      base_sel = 16'd0;
      rise     = g_reg - mn;
      fall     = r_reg - mn;
    end else if (red_min) begin
      mn       = r_reg;
      base_sel = REGION_SPAN;
      rise     = b_reg - mn;
      fall     = g_reg - mn;
    end else begin
      mn       = g_reg;
      base_sel = 16'd43520;
      rise     = r_reg - mn;
      fall     = b_reg - mn;
    end
    den_calc = {1'b0, rise} + {1'b0, fall};
    dvd_calc = {16'd0, rise} * {8'd0, REGION_SPAN};
  end

  // One restoring-division step on the current remainder
  logic [10:0] rem_shift;
  logic [10:0] rem_sub;
  logic        q_bit;
  logic [9:0]  rem_next;
  logic [23:0] dvd_next;

  // Shift in the next dividend bit and subtract the divisor when it fits.
  always_comb begin
    rem_shift = {rem_reg, dvd_reg[23]};
    rem_sub   = rem_shift - {2'b00, den_reg};
    q_bit     = (rem_shift >= {2'b00, den_reg});
    rem_next  = q_bit ? rem_sub[9:0] : rem_shift[9:0];
    dvd_next  = {dvd_reg[22:0], q_bit};
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (in_valid) state_next = SETUP;
      SETUP: state_next = (den_calc == 9'd0) ? DONE : DIV;
      DIV:   if (cnt_reg == 5'd23) state_next = DONE;
      DONE:  if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    in_ready   = (state_reg == IDLE);
    out_valid  = (state_reg == DONE);
    phase      = phase_reg;
    achromatic = ach_reg;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Datapath: capture, region setup, iterative divide, result hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg     <= 8'd0;
      g_reg     <= 8'd0;
      b_reg     <= 8'd0;
      base_reg  <= 16'd0;
      den_reg   <= 9'd0;
      dvd_reg   <= 24'd0;
      rem_reg   <= 10'd0;
      cnt_reg   <= 5'd0;
      phase_reg <= 16'd0;
      ach_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            r_reg <= red;
            g_reg <= green;
            b_reg <= blue;
          end
        end
        SETUP: begin
          base_reg <= base_sel;
          den_reg  <= den_calc;
          dvd_reg  <= dvd_calc;
          rem_reg  <= 10'd0;
          cnt_reg  <= 5'd0;
          if (den_calc == 9'd0) begin
            phase_reg <= 16'd0;
            ach_reg   <= 1'b1;
          end
        end
        DIV: begin
          dvd_reg <= dvd_next;
          rem_reg <= rem_next;
          cnt_reg <= cnt_reg + 5'd1;
          // Quotient never exceeds 21760, so it fits the low 16 bits.
          if (cnt_reg == 5'd23) begin
            phase_reg <= base_reg + dvd_next[15:0];
            ach_reg   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_to_phase.sv
// Testbench for rgb_to_phase: directed vector table, random samples against
// an arithmetic reference, backpressure, mid-divide reset, back-to-back flow.
module tb_rgb_to_phase;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  red = 8'd0, green = 8'd0, blue = 8'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] phase;
  logic        achromatic;

  int checks = 0;
  int errors = 0;

  rgb_to_phase dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .red(red), .green(green), .blue(blue), .out_valid(out_valid),
    .out_ready(out_ready), .phase(phase), .achromatic(achromatic)
  );

  always #5 clk = ~clk;

  typedef struct {
    int r, g, b;
    int exp_phase;
    int exp_ach;
    int exp_lat;
  } vec_t;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Hue from first principles: region from the minimum channel, then a
  // proportional position inside that region. Result = {ach, phase}.
  function automatic int model(input int r, input int g, input int b);
    int mn, base, rise, fall, den;
    mn = (r < g) ? r : g;
    mn = (b < mn) ? b : mn;
    if (b == mn)      begin base = 0;     rise = g - mn; fall = r - mn; end
    else if (r == mn) begin base = 21760; rise = b - mn; fall = g - mn; end
    else              begin base = 43520; rise = r - mn; fall = b - mn; end
    den = rise + fall;
    if (den == 0) return 32'h10000;
    return base + (rise * 21760) / den;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // One full transaction with latency and retire checks.
  task automatic run_sample(input int r, input int g, input int b,
                            input int exp_phase, input int exp_ach, input int exp_lat);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin step(); n++; end
    check("in_ready_before_accept", int'(in_ready), 1);
    red = r[7:0]; green = g[7:0]; blue = b[7:0]; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    red = 8'($urandom); green = 8'($urandom); blue = 8'($urandom);
    n = 0;
    while (!out_valid && n < 40) begin step(); n++; end
    check("latency", n, exp_lat);
    check("phase", int'(phase), exp_phase);
    check("achromatic", int'(achromatic), exp_ach);
    check("in_ready_in_done", int'(in_ready), 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("retired_out_valid", int'(out_valid), 0);
    $display("sample (%0d,%0d,%0d) phase=%0d ach=%0d latency=%0d", r, g, b, phase, achromatic, n);
  endtask

  vec_t vecs[9];

  initial begin
    int m, n, held_phase, held_ach;
    int exp_q[$];
    int n_sent, n_got, last_ret, got;

    vecs[0] = '{255, 0,   0,   0,     0, 25};
    vecs[1] = '{0,   255, 0,   21760, 0, 25};
    vecs[2] = '{0,   0,   255, 43520, 0, 25};
    vecs[3] = '{128, 128, 128, 0,     1, 1};
    vecs[4] = '{0,   128, 127, 32597, 0, 25};
    vecs[5] = '{255, 0,   3,   65026, 0, 25};
    vecs[6] = '{0,   0,   0,   0,     1, 1};
    vecs[7] = '{255, 255, 0,   10880, 0, 25};
    vecs[8] = '{10,  20,  30,  36266, 0, 25};

    // Reset state
    repeat (3) step();
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_phase", int'(phase), 0);
    rst_n = 1'b1;
    step();
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_achromatic", int'(achromatic), 0);

    // Directed vector table
    for (int i = 0; i < 9; i++)
      run_sample(vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].exp_phase, vecs[i].exp_ach, vecs[i].exp_lat);

    // Random samples against the reference model
    for (int i = 0; i < 20; i++) begin
      int r, g, b;
      r = $urandom_range(0, 255); g = $urandom_range(0, 255); b = $urandom_range(0, 255);
      if (i % 5 == 0) begin g = r; b = r; end
      m = model(r, g, b);
      run_sample(r, g, b, m & 32'hFFFF, m >> 16, (m >> 16) ? 1 : 25);
    end

    // Backpressure: hold result with inputs toggling
    red = 8'd0; green = 8'd128; blue = 8'd127; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin step(); n++; end
    check("bp_reached_done", int'(out_valid), 1);
    held_phase = phase; held_ach = achromatic;
    check("bp_phase", held_phase, 32597);
    for (int i = 0; i < 10; i++) begin
      red = 8'($urandom); green = 8'($urandom); blue = 8'($urandom); in_valid = 1'b1;
      step();
      check("bp_stable_phase", int'(phase), held_phase);
      check("bp_stable_ach", int'(achromatic), held_ach);
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_retired", int'(out_valid), 0);
    $display("backpressure held phase=%0d for 10 cycles", held_phase);

    // Reset in the middle of a divide
    red = 8'd255; green = 8'd0; blue = 8'd3; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (10) step();
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_phase", int'(phase), 0);
    step();
    rst_n = 1'b1;
    step();
    check("midrst_idle", int'(in_ready), 1);
    got = 0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) got++;
      step();
    end
    check("midrst_no_result", got, 0);
    run_sample(0, 255, 0, 21760, 0, 25);
    $display("mid-divide reset recovered");

    // Back-to-back samples with out_ready tied high
    out_ready = 1'b1;
    n_sent = 0; n_got = 0; last_ret = -1;
    red = 8'($urandom); green = 8'($urandom); blue = 8'($urandom); in_valid = 1'b1;
    for (int c = 0; c < 400 && n_got < 6; c++) begin
      logic accepting, retiring;
      accepting = in_valid && in_ready;
      retiring  = out_valid;
      if (accepting) begin
        exp_q.push_back(model(red, green, blue));
        n_sent++;
      end
      if (retiring) begin
        if (exp_q.size() > 0) begin
          m = exp_q.pop_front();
          check("b2b_phase", int'(phase), m & 32'hFFFF);
          check("b2b_ach", int'(achromatic), m >> 16);
        end else
          check("b2b_unexpected_result", 1, 0);
        if (last_ret >= 0) check("b2b_period", c - last_ret, 27);
        $display("b2b result %0d phase=%0d ach=%0d cycle=%0d", n_got, phase, achromatic, c);
        last_ret = c;
        n_got++;
      end
      step();
      if (accepting) begin
        red = 8'($urandom); green = 8'($urandom); blue = 8'($urandom);
        if (n_sent == 6) in_valid = 1'b0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("b2b_count", n_got, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
